// File: rtl/seg_scan_capture_pkg.sv
// Shared definitions for the multiplexed 7-segment display bus.
// Holds the segment patterns (shared with the display driver), the digit
// count, the segment bit order and small one-hot helpers.
package seg_scan_capture_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int IDX_W      = $clog2(NUM_DIGITS);
    localparam int SEG_W      = 7;

    // Segment bit order on the bus: {g,f,e,d,c,b,a}
    localparam int SEG_A = 0;
    localparam int SEG_B = 1;
    localparam int SEG_C = 2;
    localparam int SEG_D = 3;
    localparam int SEG_E = 4;
    localparam int SEG_F = 5;
    localparam int SEG_G = 6;

    localparam logic [SEG_W-1:0] SEG_0     = 7'h3F;
    localparam logic [SEG_W-1:0] SEG_1     = 7'h06;
    localparam logic [SEG_W-1:0] SEG_2     = 7'h5B;
    localparam logic [SEG_W-1:0] SEG_3     = 7'h4F;
    localparam logic [SEG_W-1:0] SEG_4     = 7'h66;
    localparam logic [SEG_W-1:0] SEG_5     = 7'h6D;
    localparam logic [SEG_W-1:0] SEG_6     = 7'h7D;
    localparam logic [SEG_W-1:0] SEG_7     = 7'h07;
    localparam logic [SEG_W-1:0] SEG_8     = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_9     = 7'h6F;
    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h00;

    // Decoder result
    typedef struct packed {
        logic [3:0] value;
        logic       blank;
        logic       err;
    } seg_dec_t;

    // One captured digit slot
    typedef struct packed {
        logic [3:0] value;
        logic       dp;
        logic       blank;
        logic       err;
    } slot_t;

    function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
        logic [IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (v[i]) idx = IDX_W'(i);
        return idx;
    endfunction

endpackage

// File: rtl/seg_scan_capture_seg7_decode.sv
// seg7_decode: combinational 7-segment pattern decoder.
//   seg_i  [6:0]  segment lines {g,f,e,d,c,b,a}
//   dec_o         {value[3:0], blank, err}; blank for the all-off pattern,
//                 err for anything that is neither a numeral nor blank.
module seg7_decode
    import seg_scan_capture_pkg::*;
(
    input  logic [SEG_W-1:0] seg_i,
    output seg_dec_t         dec_o
);

    always_comb begin
        dec_o = '{value: 4'd0, blank: 1'b0, err: 1'b0};
        case (seg_i)
            SEG_0:     dec_o.value = 4'd0;
            SEG_1:     dec_o.value = 4'd1;
            SEG_2:     dec_o.value = 4'd2;
            SEG_3:     dec_o.value = 4'd3;
            SEG_4:     dec_o.value = 4'd4;
            SEG_5:     dec_o.value = 4'd5;
            SEG_6:     dec_o.value = 4'd6;
            SEG_7:     dec_o.value = 4'd7;
            SEG_8:     dec_o.value = 4'd8;
            SEG_9:     dec_o.value = 4'd9;
            SEG_BLANK: dec_o.blank = 1'b1;
            default:   dec_o.err   = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive side of a multiplexed 4-digit 7-segment bus.
// Samples segment/dp/digit-enable lines, waits for each digit enable to
// settle, captures it into a shadow frame and publishes the frame when the
// scan wraps around.
//   clock, reset      clock, async active-low reset
//   segment[6:0], dp  segment lines and decimal point
//   bytee[3:0]        one-hot digit enables
//   digits[15:0]      decoded values, digit i at [4i+3:4i]
//   dp_out, blank, seg_err [3:0]  per-digit flags of the last frame
//   frame_valid       strobe: frame outputs updated
//   multi_err         strobe: more than one enable bit seen
//   stale             strobe: partial frame dropped by timeout
module seg_scan_capture
    import seg_scan_capture_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int FRAME_TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [SEG_W-1:0]        segment,
    input  logic                    dp,
    input  logic [NUM_DIGITS-1:0]   bytee,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dp_out,
    output logic [NUM_DIGITS-1:0]   blank,
    output logic [NUM_DIGITS-1:0]   seg_err,
    output logic                    frame_valid,
    output logic                    multi_err,
    output logic                    stale
);

    localparam int              TW       = $clog2(FRAME_TIMEOUT + 1);
    localparam logic [3:0]      SETTLE   = 4'(SETTLE_CYCLES);
    localparam logic [TW-1:0]   TMO_LAST = TW'(FRAME_TIMEOUT - 1);

    // Input sampling and dwell tracking
    logic [NUM_DIGITS-1:0] cur_q;
    logic [SEG_W-1:0]      seg_q;
    logic                  dp_q;
    logic [3:0]            dwell_q, dwell_d;
    logic                  done_q, done_d;
    logic                  multi_d;

    // Frame assembly
    slot_t [NUM_DIGITS-1:0] shadow_q, shadow_d;
    logic  [NUM_DIGITS-1:0] seen_q, seen_d;
    logic  [IDX_W-1:0]      last_idx_q, last_idx_d;
    logic                   first_q, first_d;
    logic  [TW-1:0]         tmo_q, tmo_d;

    // Outputs
    logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
    logic [NUM_DIGITS-1:0]   dp_out_q, dp_out_d;
    logic [NUM_DIGITS-1:0]   blank_q, blank_d;
    logic [NUM_DIGITS-1:0]   seg_err_q, seg_err_d;
    logic                    fv_q, fv_d;
    logic                    multi_q;
    logic                    stale_q, stale_d;

    seg_dec_t          dec;
    slot_t             new_slot;
    logic [IDX_W-1:0]  cur_idx;
    logic              capture;
    logic              wrap;

    seg7_decode u_dec (
        .seg_i (seg_q),
        .dec_o (dec)
    );

    assign cur_idx  = onehot_idx(cur_q);
    assign new_slot = '{value: dec.value, dp: dp_q, blank: dec.blank, err: dec.err};
    // done_q keeps a saturated dwell from capturing a second time.
    assign capture  = is_onehot(cur_q) && (dwell_q == SETTLE) && !done_q;
    assign wrap     = capture && !first_q && (cur_idx <= last_idx_q);

    always_comb begin
        dwell_d = dwell_q;
        done_d  = done_q;
        multi_d = 1'b0;
        if (bytee != cur_q) begin
            dwell_d = (bytee == '0) ? 4'd0 : 4'd1;
            done_d  = 1'b0;
            multi_d = (bytee != '0) && !is_onehot(bytee);
        end else if (cur_q == '0) begin
            dwell_d = 4'd0;
        end else begin
            if (dwell_q < SETTLE) dwell_d = dwell_q + 4'd1;
            if (capture)          done_d  = 1'b1;
        end
    end

    always_comb begin
        shadow_d   = shadow_q;
        seen_d     = seen_q;
        last_idx_d = last_idx_q;
        first_d    = first_q;
        tmo_d      = tmo_q;
        digits_d   = digits_q;
        dp_out_d   = dp_out_q;
        blank_d    = blank_q;
        seg_err_d  = seg_err_q;
        fv_d       = 1'b0;
        stale_d    = 1'b0;
        if (capture) begin
            tmo_d      = '0;
            first_d    = 1'b0;
            last_idx_d = cur_idx;
            if (wrap) begin
                fv_d = 1'b1;
                // Slots never enabled during the round read as blank.
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    digits_d[4*i +: 4] = seen_q[i] ? shadow_q[i].value : 4'd0;
                    dp_out_d[i]        = seen_q[i] & shadow_q[i].dp;
                    blank_d[i]         = seen_q[i] ? shadow_q[i].blank : 1'b1;
                    seg_err_d[i]       = seen_q[i] & shadow_q[i].err;
                end
                shadow_d = '0;
                seen_d   = '0;
            end
            shadow_d[cur_idx] = new_slot;
            seen_d[cur_idx]   = 1'b1;
        end else if (seen_q != '0) begin
            if (tmo_q == TMO_LAST) begin
                stale_d  = 1'b1;
                shadow_d = '0;
                seen_d   = '0;
                first_d  = 1'b1;
                tmo_d    = '0;
            end else begin
                tmo_d = tmo_q + 1'b1;
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cur_q      <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            dwell_q    <= '0;
            done_q     <= 1'b0;
            shadow_q   <= '0;
            seen_q     <= '0;
            last_idx_q <= '0;
            first_q    <= 1'b1;
            tmo_q      <= '0;
            digits_q   <= '0;
            dp_out_q   <= '0;
            blank_q    <= '0;
            seg_err_q  <= '0;
            fv_q       <= 1'b0;
            multi_q    <= 1'b0;
            stale_q    <= 1'b0;
        end else begin
            cur_q      <= bytee;
            seg_q      <= segment;
            dp_q       <= dp;
            dwell_q    <= dwell_d;
            done_q     <= done_d;
            shadow_q   <= shadow_d;
            seen_q     <= seen_d;
            last_idx_q <= last_idx_d;
            first_q    <= first_d;
            tmo_q      <= tmo_d;
            digits_q   <= digits_d;
            dp_out_q   <= dp_out_d;
            blank_q    <= blank_d;
            seg_err_q  <= seg_err_d;
            fv_q       <= fv_d;
            multi_q    <= multi_d;
            stale_q    <= stale_d;
        end
    end

    assign digits      = digits_q;
    assign dp_out      = dp_out_q;
    assign blank       = blank_q;
    assign seg_err     = seg_err_q;
    assign frame_valid = fv_q;
    assign multi_err   = multi_q;
    assign stale       = stale_q;

endmodule

// File: tb/tb_seg_scan_capture.sv
module tb_seg_scan_capture;

    localparam int S  = 2;
    localparam int FT = 1024;

    typedef struct packed {
        logic [15:0] d;
        logic [3:0]  p;
        logic [3:0]  b;
        logic [3:0]  e;
    } frame_t;

    localparam logic [6:0] PAT [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    logic        clock = 1'b0;
    logic        reset;
    logic [6:0]  segment;
    logic        dp;
    logic [3:0]  bytee;
    logic [15:0] digits;
    logic [3:0]  dp_out, blank, seg_err;
    logic        frame_valid, multi_err, stale;

    seg_scan_capture #(.SETTLE_CYCLES(S), .FRAME_TIMEOUT(FT)) dut (
        .clock(clock), .reset(reset), .segment(segment), .dp(dp), .bytee(bytee),
        .digits(digits), .dp_out(dp_out), .blank(blank), .seg_err(seg_err),
        .frame_valid(frame_valid), .multi_err(multi_err), .stale(stale)
    );

    always #5 clock = ~clock;

    int n_chk = 0, n_pass = 0;

    // Reference model: works on runs of identical bytee values as seen at clock edges.
    logic [3:0] m_prev;
    int         m_run, m_last, m_since, mcyc = 0;
    bit         m_first;
    logic [3:0] m_seen;
    logic [3:0] m_v [4];
    logic       m_p [4], m_b [4], m_e [4];
    frame_t     exp_q [$];
    frame_t     exp_out;
    int         exp_multi = 0, exp_stale = 0, exp_stale_tick = 0;

    frame_t     obs_q [$];
    int         obs_multi = 0, obs_stale = 0, obs_stale_tick = 0;

    task automatic ref_dec(input logic [6:0] s, output logic [3:0] v, output logic bl, output logic er);
        v = 4'd0; bl = (s == 7'h00); er = !bl;
        for (int k = 0; k < 10; k++)
            if (s == PAT[k]) begin v = 4'(k); er = 1'b0; end
    endtask

    task automatic model_reset();
        m_prev = 4'd0; m_run = 0; m_last = 0; m_since = 0; m_first = 1'b1; m_seen = 4'd0;
        exp_out = '0;
    endtask

    task automatic model_step(input logic [3:0] b, input logic [6:0] s, input logic d);
        int idx;
        frame_t f;
        mcyc++;
        if (b != m_prev) m_run = 1; else m_run++;
        if (b != m_prev && $countones(b) > 1) exp_multi++;
        m_prev = b;
        if ($countones(b) == 1 && m_run == S) begin
            idx = 0;
            for (int i = 0; i < 4; i++) if (b[i]) idx = i;
            if (!m_first && idx <= m_last) begin
                f = '0;
                for (int i = 0; i < 4; i++) begin
                    if (m_seen[i]) begin
                        f.d[4*i +: 4] = m_v[i]; f.p[i] = m_p[i]; f.b[i] = m_b[i]; f.e[i] = m_e[i];
                    end else f.b[i] = 1'b1;
                end
                exp_q.push_back(f);
                exp_out = f;
                m_seen = 4'd0;
            end
            ref_dec(s, m_v[idx], m_b[idx], m_e[idx]);
            m_p[idx] = d;
            m_seen[idx] = 1'b1;
            m_first = 1'b0; m_last = idx; m_since = 0;
        end else if (m_seen != 0) begin
            m_since++;
            if (m_since == FT) begin
                exp_stale++; exp_stale_tick = mcyc;
                m_seen = 4'd0; m_first = 1'b1; m_since = 0;
            end
        end else m_since = 0;
    endtask

    always @(negedge clock) begin
        if (reset) begin
            if (frame_valid) obs_q.push_back({digits, dp_out, blank, seg_err});
            if (multi_err) obs_multi++;
            if (stale) begin obs_stale++; obs_stale_tick = mcyc; end
        end
    end

    function automatic frame_t cur_out();
        frame_t f;
        f = {digits, dp_out, blank, seg_err};
        return f;
    endfunction

    task automatic cyc(input logic [3:0] b, input logic [6:0] s, input logic d);
        @(negedge clock);
        bytee = b; segment = s; dp = d;
        @(posedge clock);
        model_step(b, s, d);
    endtask

    task automatic dwell(input logic [3:0] b, input logic [6:0] s, input logic d, input int n);
        repeat (n) cyc(b, s, d);
    endtask

    task automatic flush();
        repeat (4) cyc(4'd0, 7'd0, 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b0; bytee = 4'd0; segment = 7'd0; dp = 1'b0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        n_chk++;
        if ({digits, dp_out, blank, seg_err, frame_valid, multi_err, stale} !== 31'd0)
            $display("FAIL reset_state: got %h want 0", {digits, dp_out, blank, seg_err, frame_valid, multi_err, stale});
        else n_pass++;
        @(negedge clock); reset = 1'b1;
    endtask

    task automatic test_scan_1234();
        int ob = obs_q.size(), eb = exp_q.size();
        frame_t o;
        for (int r = 0; r < 3; r++)
            for (int i = 0; i < 4; i++) dwell(4'(1 << i), PAT[i+1], 1'($urandom_range(0, 1)), 8);
        flush();
        n_chk++;
        if (obs_q.size() - ob != 2) $display("FAIL scan1234_count: got %0d want 2", obs_q.size() - ob);
        else n_pass++;
        o = cur_out();
        n_chk++;
        if ({o.d, o.b, o.e} !== {16'h4321, 4'h0, 4'h0})
            $display("FAIL scan1234_frame: got d=%h b=%b e=%b want d=4321 b=0000 e=0000", o.d, o.b, o.e);
        else n_pass++;
        n_chk++;
        if (o !== exp_out) $display("FAIL scan1234_model: got %h want %h", o, exp_out);
        else n_pass++;
        n_chk++;
        if (obs_q.size() - ob != exp_q.size() - eb)
            $display("FAIL scan1234_model_count: got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int ob = obs_q.size();
        frame_t o;
        dwell(4'b0001, PAT[1], 1'b0, 8);
        dwell(4'b0100, PAT[8], 1'b0, 1);
        dwell(4'b0010, PAT[2], 1'b0, 8);
        dwell(4'b0100, PAT[3], 1'b0, 8);
        dwell(4'b1000, PAT[4], 1'b0, 8);
        dwell(4'b0001, PAT[1], 1'b0, 8);
        flush();
        o = cur_out();
        n_chk++;
        if (obs_q.size() - ob != 2) $display("FAIL glitch_count: got %0d want 2", obs_q.size() - ob);
        else n_pass++;
        n_chk++;
        if (o.d !== 16'h4321) $display("FAIL glitch_digits: got %h want 4321", o.d);
        else n_pass++;
        n_chk++;
        if (o !== exp_out) $display("FAIL glitch_model: got %h want %h", o, exp_out);
        else n_pass++;
    endtask

    task automatic test_partial();
        frame_t o;
        repeat (3) begin
            dwell(4'b0001, PAT[5], 1'($urandom_range(0, 1)), $urandom_range(S, 6));
            dwell(4'b0010, PAT[9], 1'($urandom_range(0, 1)), $urandom_range(S, 6));
        end
        flush();
        o = cur_out();
        n_chk++;
        if (o.d[7:0] !== 8'h95 || o.b !== 4'b1100)
            $display("FAIL partial_frame: got d=%h b=%b want d[7:0]=95 b=1100", o.d, o.b);
        else n_pass++;
        n_chk++;
        if (o !== exp_out) $display("FAIL partial_model: got %h want %h", o, exp_out);
        else n_pass++;
    endtask

    task automatic test_seg_err();
        frame_t o;
        repeat (2) begin
            dwell(4'b0001, PAT[1], 1'b0, 4);
            dwell(4'b0010, 7'h55, 1'b0, 4);
            dwell(4'b0100, PAT[3], 1'b0, 4);
            dwell(4'b1000, PAT[4], 1'b0, 4);
        end
        dwell(4'b0001, PAT[1], 1'b0, 4);
        flush();
        o = cur_out();
        n_chk++;
        if ({o.d, o.b, o.e} !== {16'h4301, 4'b0000, 4'b0010})
            $display("FAIL seg_err_frame: got d=%h b=%b e=%b want d=4301 b=0000 e=0010", o.d, o.b, o.e);
        else n_pass++;
        n_chk++;
        if (o !== exp_out) $display("FAIL seg_err_model: got %h want %h", o, exp_out);
        else n_pass++;
    endtask

    task automatic test_multi();
        int ob = obs_q.size(), mb = obs_multi;
        frame_t saved = cur_out();
        dwell(4'b0011, PAT[8], 1'b1, 5);
        flush();
        n_chk++;
        if (obs_multi - mb != 1) $display("FAIL multi_count: got %0d want 1", obs_multi - mb);
        else n_pass++;
        n_chk++;
        if (obs_q.size() != ob || cur_out() !== saved)
            $display("FAIL multi_no_frame: frames=%0d out=%h want frames=%0d out=%h", obs_q.size(), cur_out(), ob, saved);
        else n_pass++;
    endtask

    task automatic test_timeout_and_reset();
        int sb = obs_stale, ob;
        frame_t saved;
        dwell(4'b0001, PAT[7], 1'b0, 8);
        dwell(4'b0010, PAT[8], 1'b0, 8);
        saved = cur_out();
        repeat (1100) cyc(4'd0, 7'd0, 1'b0);
        n_chk++;
        if (obs_stale - sb != 1) $display("FAIL stale_count: got %0d want 1", obs_stale - sb);
        else n_pass++;
        n_chk++;
        if (obs_stale_tick != exp_stale_tick + 1)
            $display("FAIL stale_time: got %0d want %0d", obs_stale_tick, exp_stale_tick + 1);
        else n_pass++;
        n_chk++;
        if (cur_out() !== saved || saved !== exp_out)
            $display("FAIL stale_hold: got %h want %h", cur_out(), exp_out);
        else n_pass++;
        // Reset in the middle of a round
        dwell(4'b0001, PAT[1], 1'b0, 8);
        dwell(4'b0010, PAT[2], 1'b0, 3);
        @(negedge clock);
        bytee = 4'd0; segment = 7'd0; dp = 1'b0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        n_chk++;
        if ({digits, dp_out, blank, seg_err, frame_valid, multi_err, stale} !== 31'd0)
            $display("FAIL midreset_clear: got %h want 0", {digits, dp_out, blank, seg_err});
        else n_pass++;
        repeat (2) @(posedge clock);
        @(negedge clock); reset = 1'b1;
        ob = obs_q.size();
        for (int i = 0; i < 4; i++) dwell(4'(1 << i), PAT[i+1], 1'b0, 6);
        flush();
        n_chk++;
        if (obs_q.size() != ob) $display("FAIL post_reset_round1: got %0d frames want 0", obs_q.size() - ob);
        else n_pass++;
        for (int i = 0; i < 4; i++) dwell(4'(1 << i), PAT[i+1], 1'b0, 6);
        flush();
        n_chk++;
        if (obs_q.size() - ob != 1 || digits !== 16'h4321)
            $display("FAIL post_reset_round2: got %0d frames d=%h want 1 frame d=4321", obs_q.size() - ob, digits);
        else n_pass++;
    endtask

    function automatic logic [6:0] pick_seg();
        int r = $urandom_range(0, 9);
        if (r < 8) return PAT[$urandom_range(0, 9)];
        else if (r == 8) return 7'h00;
        else return 7'($urandom);
    endfunction

    task automatic test_random();
        int ob = obs_q.size(), eb = exp_q.size(), mb = obs_multi, emb = exp_multi;
        int pos = 0, n;
        repeat (250) begin
            int kind = $urandom_range(0, 9);
            int len;
            logic [3:0] b;
            if (kind < 7) begin
                pos = ($urandom_range(0, 4) == 0) ? (pos + 2) % 4 : (pos + 1) % 4;
                b = 4'(1 << pos); len = $urandom_range(1, 6);
            end else if (kind == 7) begin
                b = 4'(1 << $urandom_range(0, 3)); len = 1;
            end else if (kind == 8) begin
                do b = 4'($urandom_range(3, 15)); while ($countones(b) < 2);
                len = $urandom_range(1, 3);
            end else begin
                b = 4'd0; len = $urandom_range(1, 3);
            end
            dwell(b, pick_seg(), 1'($urandom_range(0, 1)), len);
        end
        flush();
        n_chk++;
        if (obs_q.size() - ob != exp_q.size() - eb)
            $display("FAIL random_count: got %0d want %0d", obs_q.size() - ob, exp_q.size() - eb);
        else n_pass++;
        n = exp_q.size() - eb;
        if (obs_q.size() - ob < n) n = obs_q.size() - ob;
        for (int k = 0; k < n; k++) begin
            n_chk++;
            if (obs_q[ob+k] !== exp_q[eb+k]) $display("FAIL random_frame%0d: got %h want %h", k, obs_q[ob+k], exp_q[eb+k]);
            else n_pass++;
        end
        n_chk++;
        if (obs_multi - mb != exp_multi - emb)
            $display("FAIL random_multi: got %0d want %0d", obs_multi - mb, exp_multi - emb);
        else n_pass++;
        n_chk++;
        if (cur_out() !== exp_out) $display("FAIL random_out: got %h want %h", cur_out(), exp_out);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_scan_1234();
        test_glitch();
        test_partial();
        test_seg_err();
        test_multi();
        test_timeout_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
